// File: rtl/noc_vc_grant_arbiter_if.sv
// noc_vc_grant_arbiter_if: per-VC request/handshake inputs and one-hot grant outputs of the VC arbiter.
// slave is the arbiter side, master is the VC buffers / merge side driving the requests.
interface noc_vc_grant_arbiter_if #(
    parameter int CHANNELS = 4
);
    localparam int IW = $clog2(CHANNELS);
    logic [CHANNELS-1:0] i_vc_valid;
    logic [CHANNELS-1:0] i_vc_head;
    logic [CHANNELS-1:0] i_vc_tail;
    logic [CHANNELS-1:0] i_vc_credit_ok;
    logic [CHANNELS-1:0] i_vc_ready;
    logic [CHANNELS-1:0] o_vc_grant;
    logic [IW-1:0]       o_grant_id;
    logic                o_busy;
    logic                o_timeout;
    modport master (
        output i_vc_valid, i_vc_head, i_vc_tail, i_vc_credit_ok, i_vc_ready,
        input  o_vc_grant, o_grant_id, o_busy, o_timeout
    );
    modport slave (
        input  i_vc_valid, i_vc_head, i_vc_tail, i_vc_credit_ok, i_vc_ready,
        output o_vc_grant, o_grant_id, o_busy, o_timeout
    );
endinterface

// File: rtl/noc_vc_grant_arbiter.sv
// noc_vc_grant_arbiter: round-robin packet-level VC arbiter with credit check; grant locked head to tail.
// Optional watchdog release under NOC_VC_ARB_TIMEOUT_EN.
module noc_vc_grant_arbiter #(
    parameter int CHANNELS       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                    noc_clk,
    input logic                    noc_rst,
    noc_vc_grant_arbiter_if.slave  bus
);
    localparam int IW = $clog2(CHANNELS);
    localparam logic [IW:0] CH = (IW+1)'(CHANNELS);

    if (CHANNELS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("noc_vc_grant_arbiter: CHANNELS and TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic {IDLE, LOCKED} state_t;
    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       gid;
    logic [IW-1:0]       gid_next;
    logic [IW-1:0]       pick;
    logic [IW:0]         s;
    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] grant;
    logic                found;
    logic                xfer;
    logic                tail_xfer;
    logic                wd_hit;

    assign elig      = bus.i_vc_valid & bus.i_vc_head & bus.i_vc_credit_ok;
    assign xfer      = bus.i_vc_valid[gid] & bus.i_vc_ready[gid];
    assign tail_xfer = xfer & bus.i_vc_tail[gid];
    assign gid_next  = (gid == IW'(CHANNELS-1)) ? '0 : gid + 1'b1;

    // Scan from the farthest offset down so the nearest eligible VC at/after ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        s     = '0;
        for (int k = CHANNELS-1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            s = (s >= CH) ? s - CH : s;
            if (elig[s[IW-1:0]]) begin
                found = 1'b1;
                pick  = s[IW-1:0];
            end
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state <= IDLE;
            ptr   <= '0;
            gid   <= '0;
            grant <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= LOCKED;
                gid   <= pick;
                grant <= CHANNELS'(1) << pick;
            end
        end else if (tail_xfer || wd_hit) begin
            state <= IDLE;
            gid   <= '0;
            grant <= '0;
            ptr   <= gid_next;
        end
    end

    assign bus.o_vc_grant = grant;
    assign bus.o_grant_id = gid;
    assign bus.o_busy     = state == LOCKED;

`ifdef NOC_VC_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    logic [WW-1:0] wd_cnt;
    logic          timeout;

    // Counts consecutive locked cycles without a transfer; fires on the TIMEOUT_CYCLES-th.
    assign wd_hit = state == LOCKED && !xfer && wd_cnt == WW'(TIMEOUT_CYCLES-1);

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= wd_hit;
            wd_cnt  <= (state != LOCKED || xfer || wd_hit) ? '0 : wd_cnt + 1'b1;
        end
    end

    assign bus.o_timeout = timeout;
`else
    assign wd_hit        = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_noc_vc_grant_arbiter.sv
// tb_noc_vc_grant_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a packet-level reference model of the arbiter.
module tb_noc_vc_grant_arbiter;
    localparam int CH = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_vc_grant_arbiter_if #(.CHANNELS(CH)) bus ();
    noc_vc_grant_arbiter #(.CHANNELS(CH), .TIMEOUT_CYCLES(TO)) dut (
        .noc_clk (clk),
        .noc_rst (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_busy, m_g, m_ptr, m_wd, m_to;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_wd = 0; m_to = 0;
    endtask

    task automatic model_release(input int by_timeout);
        m_busy = 0;
        m_ptr  = (m_g + 1) % CH;
        m_g    = 0;
        m_wd   = 0;
        m_to   = by_timeout;
    endtask

    // Packet-level behaviour at one clock edge, from the inputs present before it.
    task automatic model_edge();
        int j, moved;
        m_to = 0;
        if (m_busy == 0) begin
            for (int k = 0; k < CH; k++) begin
                j = (m_ptr + k) % CH;
                if (m_busy == 0 && bus.i_vc_valid[j] && bus.i_vc_head[j] && bus.i_vc_credit_ok[j]) begin
                    m_busy = 1;
                    m_g    = j;
                    m_wd   = 0;
                end
            end
        end else begin
            moved = int'(bus.i_vc_valid[m_g] && bus.i_vc_ready[m_g]);
            if (moved == 1 && bus.i_vc_tail[m_g]) model_release(0);
            else begin
                m_wd = (moved == 1) ? 0 : m_wd + 1;
`ifdef NOC_VC_ARB_TIMEOUT_EN
                if (m_wd == TO) model_release(1);
`endif
            end
        end
    endtask

    task automatic check_out();
        chk("grant", int'(bus.o_vc_grant), m_busy ? (1 << m_g) : 0);
        chk("grant_id", int'(bus.o_grant_id), m_busy ? m_g : 0);
        chk("busy", int'(bus.o_busy), m_busy);
        chk("timeout", int'(bus.o_timeout), m_to);
        chk("onehot", int'($countones(bus.o_vc_grant) <= 1), 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic drive(input logic [CH-1:0] v, h, t, c, r);
        bus.i_vc_valid = v; bus.i_vc_head = h; bus.i_vc_tail = t;
        bus.i_vc_credit_ok = c; bus.i_vc_ready = r;
    endtask

    // Releases any locked packet and leaves the arbiter idle with nothing eligible.
    task automatic drain();
        drive(4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
        step();
        step();
    endtask

    task automatic async_rst();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_out();
        chk("rst_async_busy", int'(bus.o_busy), 0);
        #1 rst = 1'b0;
    endtask

    function automatic logic [CH-1:0] rnd(input int pct);
        logic [CH-1:0] r;
        for (int b = 0; b < CH; b++) r[b] = $urandom_range(0, 99) < pct;
        return r;
    endfunction

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        drive('0, '0, '0, '0, '0);
        model_reset();
        #12;
        check_out();
        rst = 1'b0;

        // single 3-flit packet on VC2
        drive(4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b1111);
        step();
        chk("t1_grant", int'(bus.o_vc_grant), 4);
        chk("t1_id", int'(bus.o_grant_id), 2);
        drive(4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        step();
        step();
        drive(4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'b1111);
        step();
        chk("t1_release", int'(bus.o_vc_grant), 0);

        // fairness: pointer is now 3, so VC3 goes first, then 0,1,2,3,0
        drive(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        step();
        chk("t1_ptr", int'(bus.o_vc_grant), 8);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_bubble", int'(bus.o_vc_grant), 0);
            step();
            chk("t2_order", int'(bus.o_grant_id), order[i]);
        end
        drain();

        // credit block
        drive(4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1111);
        step();
        chk("t3_vc3", int'(bus.o_vc_grant), 8);
        bus.i_vc_credit_ok = 4'b1010;
        step();
        step();
        chk("t3_vc1", int'(bus.o_grant_id), 1);
        drain();

        // back-pressure on VC0
        drive(4'b0001, 4'b0001, 4'b0000, 4'b1111, 4'b1111);
        step();
        drive(4'b0011, 4'b0010, 4'b0000, 4'b1111, 4'b1110);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold", int'(bus.o_vc_grant), 1);
        end
        drive(4'b0011, 4'b0010, 4'b0001, 4'b1111, 4'b1111);
        step();
        chk("t4_release", int'(bus.o_vc_grant), 0);
        step();
        chk("t4_next", int'(bus.o_grant_id), 1);
        drain();

        // reset mid-packet on VC2, then pointer must be back at 0
        drive(4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b1111);
        step();
        chk("t5_locked", int'(bus.o_vc_grant), 4);
        async_rst();
        chk("t5_drop", int'(bus.o_vc_grant), 0);
        drive(4'b0011, 4'b0011, 4'b0000, 4'b1111, 4'b1111);
        step();
        chk("t5_vc0", int'(bus.o_vc_grant), 1);
        drain();

        // stalled VC1 with VC2 waiting
        drive(4'b0010, 4'b0010, 4'b0000, 4'b1111, 4'b1111);
        step();
        drive(4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b1111);
        for (int i = 0; i < TO; i++) step();
`ifdef NOC_VC_ARB_TIMEOUT_EN
        chk("t6_pulse", int'(bus.o_timeout), 1);
        chk("t6_drop", int'(bus.o_vc_grant), 0);
        step();
        chk("t6_pulse_end", int'(bus.o_timeout), 0);
        chk("t6_next", int'(bus.o_vc_grant), 4);
`else
        step();
        chk("t6_held", int'(bus.o_vc_grant), 2);
`endif
        drain();

        // randomized traffic with varying load
        for (int i = 0; i < 3000; i++) begin
            int pv;
            pv = ((i / 250) % 3 == 0) ? 90 : ((i / 250) % 3 == 1) ? 50 : 10;
            drive(rnd(pv), rnd(50), rnd(35), rnd(70), rnd(70));
            step();
            if (i % 500 == 377 && m_busy == 1) async_rst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
